// File: rtl/img_pkg.sv
// Shared constants for the image memory loader: frame geometry, bus widths,
// read-port latency, checksum width and the loader FSM state encodings.
package img_pkg;

    localparam int unsigned DEPTH        = 27000;
    localparam int unsigned ADDR_W       = 15;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned READ_LATENCY = 1;
    localparam int unsigned SUM_W        = 24;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_CHECK  = 2'd3;

endpackage

// File: rtl/img_rd_checksum.sv
// Read-back checksum: delays the read-issue strobe by READ_LATENCY cycles so it
// lines up with the memory data, and accumulates the data into a byte sum.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear       - synchronous clear of the pipeline and the sum
//   valid_in    - an address was presented to the memory this cycle
//   last_in     - that address is the final one of the frame
//   data        - memory read data
//   sum         - running read-back sum
//   last_out    - final sample is being accumulated at the coming edge
module img_rd_checksum #(
    parameter int unsigned READ_LATENCY = img_pkg::READ_LATENCY,
    parameter int unsigned SUM_W        = img_pkg::SUM_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      valid_in,
    input  logic                      last_in,
    input  logic [img_pkg::PIX_W-1:0] data,
    output logic [SUM_W-1:0]          sum,
    output logic                      last_out
);
    logic [READ_LATENCY-1:0] vld_q,  vld_d;
    logic [READ_LATENCY-1:0] last_q, last_d;
    logic [SUM_W-1:0]        sum_q,  sum_d;

    // Shift the strobes one stage per cycle; add data when the tail stage fires.
    always_comb begin
        vld_d  = READ_LATENCY'({vld_q, valid_in});
        last_d = READ_LATENCY'({last_q, last_in});
        sum_d  = sum_q;
        if (vld_q[READ_LATENCY-1]) begin
            sum_d = sum_q + SUM_W'(data);
        end
        if (clear) begin
            vld_d  = '0;
            last_d = '0;
            sum_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
            sum_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
            sum_q  <= sum_d;
        end
    end

    assign sum      = sum_q;
    assign last_out = vld_q[READ_LATENCY-1] & last_q[READ_LATENCY-1];

endmodule

// File: rtl/img_mem_loader.sv
// Writes one frame of pixel bytes into the image BRAM at addresses 0..DEPTH-1,
// then reads the whole frame back and compares the read sum with the write sum.
// Ports:
//   clka, rst_n            - clock, synchronous active-low reset
//   start, abort           - begin a frame load (idle only) / return to idle
//   s_data/s_valid/s_ready - pixel byte stream
//   mem_wea/mem_addra/mem_dina/mem_douta - BRAM port A
//   busy, done, verify_ok  - status; done pulses once per completed verify
//   err_overflow           - sticky: bytes offered after the frame was full
//   wr_sum                 - sum of written bytes
module img_mem_loader #(
    parameter int unsigned DEPTH        = img_pkg::DEPTH,
    parameter int unsigned ADDR_W       = img_pkg::ADDR_W,
    parameter int unsigned READ_LATENCY = img_pkg::READ_LATENCY,
    parameter int unsigned SUM_W        = img_pkg::SUM_W
) (
    input  logic                      clka,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [img_pkg::PIX_W-1:0] s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      mem_wea,
    output logic [ADDR_W-1:0]         mem_addra,
    output logic [img_pkg::PIX_W-1:0] mem_dina,
    input  logic [img_pkg::PIX_W-1:0] mem_douta,
    output logic                      busy,
    output logic                      done,
    output logic                      verify_ok,
    output logic                      err_overflow,
    output logic [SUM_W-1:0]          wr_sum
);
    import img_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state_q,   state_d;
    logic              s_ready_q, s_ready_d;
    logic              wea_q,     wea_d;
    logic [ADDR_W-1:0] addra_q,   addra_d;
    logic [PIX_W-1:0]  dina_q,    dina_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              ok_q,      ok_d;
    logic              ovf_q,     ovf_d;
    logic [SUM_W-1:0]  wr_sum_q,  wr_sum_d;
    logic [ADDR_W-1:0] wr_cnt_q,  wr_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_vld_q,  rd_vld_d;
    logic              rd_last_q, rd_last_d;

    logic              sum_clear;
    logic [SUM_W-1:0]  rd_sum;
    logic              rd_last;

    // Next-state and registered-output logic; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        wea_d     = 1'b0;
        addra_d   = addra_q;
        dina_d    = dina_q;
        done_d    = 1'b0;
        ok_d      = ok_q;
        ovf_d     = ovf_q;
        wr_sum_d  = wr_sum_q;
        wr_cnt_d  = wr_cnt_q;
        rd_addr_d = rd_addr_q;
        rd_pend_d = rd_pend_q;
        rd_vld_d  = 1'b0;
        rd_last_d = 1'b0;
        sum_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d   = ST_WRITE;
                    wr_sum_d  = '0;
                    ok_d      = 1'b0;
                    ovf_d     = 1'b0;
                    wr_cnt_d  = '0;
                    sum_clear = 1'b1;
                end
            end
            ST_WRITE: begin
                if (s_valid && s_ready_q) begin
                    wea_d    = 1'b1;
                    addra_d  = wr_cnt_q;
                    dina_d   = s_data;
                    wr_sum_d = wr_sum_q + SUM_W'(s_data);
                    wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    if (wr_cnt_q == LAST_ADDR) begin
                        state_d   = ST_VERIFY;
                        rd_addr_d = '0;
                        rd_pend_d = 1'b1;
                    end
                end
            end
            ST_VERIFY: begin
                // Issue one read address per cycle until the last one is out.
                if (rd_pend_q) begin
                    addra_d   = rd_addr_q;
                    rd_vld_d  = 1'b1;
                    rd_last_d = (rd_addr_q == LAST_ADDR);
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_pend_d = 1'b0;
                    end
                end
                if (rd_last) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                ok_d    = (rd_sum == wr_sum_q);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Any byte offered once the frame is full is an overflow.
        if ((state_q == ST_VERIFY || state_q == ST_CHECK) && s_valid) begin
            ovf_d = 1'b1;
        end

        if (abort) begin
            state_d   = ST_IDLE;
            wea_d     = 1'b0;
            done_d    = 1'b0;
            ok_d      = 1'b0;
            rd_pend_d = 1'b0;
            rd_vld_d  = 1'b0;
            rd_last_d = 1'b0;
            sum_clear = 1'b1;
        end

        s_ready_d = (state_d == ST_WRITE);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b0;
            wea_q     <= 1'b0;
            addra_q   <= '0;
            dina_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            ovf_q     <= 1'b0;
            wr_sum_q  <= '0;
            wr_cnt_q  <= '0;
            rd_addr_q <= '0;
            rd_pend_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            wea_q     <= wea_d;
            addra_q   <= addra_d;
            dina_q    <= dina_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
            ovf_q     <= ovf_d;
            wr_sum_q  <= wr_sum_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_addr_q <= rd_addr_d;
            rd_pend_q <= rd_pend_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
        end
    end

    // rd_vld_q is in phase with mem_addra, so the checksum delays it by the read latency.
    img_rd_checksum #(
        .READ_LATENCY (READ_LATENCY),
        .SUM_W        (SUM_W)
    ) u_rd_checksum (
        .clk      (clka),
        .rst_n    (rst_n),
        .clear    (sum_clear),
        .valid_in (rd_vld_q),
        .last_in  (rd_last_q),
        .data     (mem_douta),
        .sum      (rd_sum),
        .last_out (rd_last)
    );

    assign s_ready      = s_ready_q;
    assign mem_wea      = wea_q;
    assign mem_addra    = addra_q;
    assign mem_dina     = dina_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign verify_ok    = ok_q;
    assign err_overflow = ovf_q;
    assign wr_sum       = wr_sum_q;

endmodule
